// File: rtl/bus_master_if.sv
// Core-side request bundle plus the shared tri-state system bus.
// The bus resolves master and responder drive enables in one place.
interface bus_master_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        ready;
  logic        done;
  logic [31:0] rdata;
  logic        load;
  logic        rd;
  logic        wr;

  logic        m_oe;
  logic [31:0] m_out;
  logic        s_oe;
  logic [31:0] s_out;
  logic        bus_oe;
  logic [31:0] bus_val;
  wire  [31:0] bus;

  assign bus_oe  = m_oe | s_oe;
  assign bus_val = m_oe ? m_out : s_out;
  assign bus     = bus_oe ? bus_val : 'z;

  modport master (
    input  req, we, addr, wdata, bus,
    output ready, done, rdata,
    output load, rd, wr,
    output m_oe, m_out
  );

  modport slave (
    input  load, rd, wr, bus,
    output s_oe, s_out
  );
endinterface

// File: rtl/bus_master.sv
// Single-word initiator for the shared tri-state system bus:
// address-load, then read (with wait states) or write strobe.
module bus_master #(
  parameter int unsigned READ_WAIT = 0,
  parameter int unsigned ADDR_W    = 32
) (
  input  logic         clk,
  input  logic         rst,
  bus_master_if.master m
);
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ADDR  = 3'd1;
  localparam logic [2:0] S_READ  = 3'd2;
  localparam logic [2:0] S_WRITE = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]        state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] wdata_q, wdata_d;
  logic [ADDR_W-1:0] rdata_q, rdata_d;
  logic              we_q, we_d;
  logic              load_s, rd_s, wr_s;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    we_d    = we_q;
    case (state_q)
      S_IDLE: begin
        if (m.req) begin
          addr_d  = m.addr;
          wdata_d = m.wdata;
          we_d    = m.we;
          state_d = S_ADDR;
        end
      end
      S_ADDR: begin
        cnt_d   = 4'(READ_WAIT);
        state_d = we_q ? S_WRITE : S_READ;
      end
      S_READ: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          rdata_d = m.bus;
          state_d = S_DONE;
        end
      end
      S_WRITE: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      we_q    <= we_d;
    end
  end

  // rst kills wr in the same cycle so a write cut by reset never commits
  assign load_s = (state_q == S_ADDR);
  assign rd_s   = (state_q == S_READ);
  assign wr_s   = (state_q == S_WRITE) & ~rst;

  assign m.ready = (state_q == S_IDLE);
  assign m.done  = (state_q == S_DONE);
  assign m.rdata = rdata_q;
  assign m.load  = load_s;
  assign m.rd    = rd_s;
  assign m.wr    = wr_s;
  assign m.m_oe  = load_s | wr_s;
  assign m.m_out = load_s ? addr_q : wdata_q;
endmodule

// File: tb/tb_bus_master.sv
// Directed bench: RAM + LED responder on the bus, vector table
// for single transactions, hand sequences for corner cases.
module tb_bus_master;
  logic clk;
  logic rst;

  bus_master_if bif0 ();
  bus_master_if bif2 ();

  bus_master #(.READ_WAIT(0), .ADDR_W(32)) u0 (
    .clk(clk), .rst(rst), .m(bif0)
  );
  bus_master #(.READ_WAIT(2), .ADDR_W(32)) u2 (
    .clk(clk), .rst(rst), .m(bif2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int viol   = 0;

  logic [31:0] ram [0:31];
  logic [7:0]  leds;
  logic [31:0] ra0, ra2;

  function automatic logic hit(input logic [31:0] a);
    return a <= 32'h80;
  endfunction

  function automatic logic [31:0] rval(input logic [31:0] a);
    if (a == 32'h80) return {24'h0, leds};
    return ram[a[6:2]];
  endfunction

  assign bif0.s_oe  = bif0.rd && hit(ra0);
  assign bif0.s_out = rval(ra0);
  assign bif2.s_oe  = bif2.rd && hit(ra2);
  assign bif2.s_out = rval(ra2);

  always @(posedge clk) begin
    if (rst) leds <= 8'h00;
    if (bif0.load) ra0 <= bif0.bus;
    if (bif2.load) ra2 <= bif2.bus;
    if (bif0.wr && hit(ra0)) begin
      if (ra0 == 32'h80) leds <= bif0.bus[7:0];
      else ram[ra0[6:2]] <= bif0.bus;
    end
  end

  // strobes mutually exclusive; bus driven exactly under load/wr
  always @(negedge clk) begin
    if (!rst) begin
      if (int'(bif0.load) + int'(bif0.rd)
          + int'(bif0.wr) > 1) viol++;
      if (bif0.m_oe != (bif0.load | bif0.wr)) viol++;
      if (bif0.m_oe && bif0.s_oe) viol++;
      if (int'(bif2.load) + int'(bif2.rd)
          + int'(bif2.wr) > 1) viol++;
      if (bif2.m_oe != (bif2.load | bif2.wr)) viol++;
      if (bif2.m_oe && bif2.s_oe) viol++;
    end
  end

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic xact(input  logic        w,
                      input  logic [31:0] a,
                      input  logic [31:0] d,
                      output int          lat,
                      output int          nld,
                      output int          nrd,
                      output int          nwr,
                      output logic [31:0] rdat,
                      output logic        rdy_done,
                      output logic        rdy_after);
    lat = 0; nld = 0; nrd = 0; nwr = 0;
    rdat = '0; rdy_done = 1'b1; rdy_after = 1'b0;
    @(negedge clk);
    bif0.req = 1'b1; bif0.we = w;
    bif0.addr = a; bif0.wdata = d;
    @(negedge clk);
    bif0.req = 1'b0; bif0.we = ~w;
    bif0.addr = 32'hFFFF_FFFC; bif0.wdata = ~d;
    for (int n = 1; n <= 20; n++) begin
      if (bif0.load) nld++;
      if (bif0.rd) nrd++;
      if (bif0.wr) nwr++;
      if (bif0.done) begin
        lat = n;
        rdat = bif0.rdata;
        rdy_done = bif0.ready;
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
    rdy_after = bif0.ready;
  endtask

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  vec_t v [8];

  initial begin
    int          lat, nld, nrd, nwr, ndone;
    logic [31:0] rdat;
    logic        rdy_d, rdy_a;

    v[0] = '{1'b1, 32'h40, 32'hDEADBEEF, 32'h0};
    v[1] = '{1'b0, 32'h40, 32'h0, 32'hDEADBEEF};
    v[2] = '{1'b1, 32'h80, 32'h000000A5, 32'h0};
    v[3] = '{1'b0, 32'h80, 32'h0, 32'h000000A5};
    v[4] = '{1'b1, 32'h44, 32'h0BADF00D, 32'h0};
    v[5] = '{1'b0, 32'h44, 32'h0, 32'h0BADF00D};
    v[6] = '{1'b1, 32'h48, 32'h11111111, 32'h0};
    v[7] = '{1'b0, 32'h40, 32'h0, 32'hDEADBEEF};

    bif0.req = 1'b0; bif0.we = 1'b0;
    bif0.addr = '0; bif0.wdata = '0;
    bif2.req = 1'b0; bif2.we = 1'b0;
    bif2.addr = '0; bif2.wdata = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", 32'(bif0.ready), 32'd1);
    chk("rst_done",  32'(bif0.done), 32'd0);
    chk("rst_strb",
        {29'd0, bif0.load, bif0.rd, bif0.wr}, 32'd0);
    chk("rst_oe",    32'(bif0.m_oe), 32'd0);
    chk("rst_rdata", bif0.rdata, 32'h0);
    chk("rst2_ready", 32'(bif2.ready), 32'd1);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      xact(v[i].we, v[i].addr, v[i].wdata,
           lat, nld, nrd, nwr, rdat, rdy_d, rdy_a);
      chk($sformatf("v%0d_lat", i), 32'(lat), 32'd3);
      chk($sformatf("v%0d_load", i), 32'(nld), 32'd1);
      chk($sformatf("v%0d_rd", i), 32'(nrd),
          v[i].we ? 32'd0 : 32'd1);
      chk($sformatf("v%0d_wr", i), 32'(nwr),
          v[i].we ? 32'd1 : 32'd0);
      chk($sformatf("v%0d_rdy", i),
          {30'd0, rdy_d, rdy_a}, 32'd1);
      if (!v[i].we)
        chk($sformatf("v%0d_rdata", i), rdat, v[i].exp);
      if (v[i].we && v[i].addr == 32'h80)
        chk("leds", {24'h0, leds}, 32'h000000A5);
    end

    // READ_WAIT=2 instance: rd held 3 cycles, done at T5
    @(negedge clk);
    bif2.req = 1'b1; bif2.we = 1'b0; bif2.addr = 32'h40;
    @(negedge clk);
    bif2.req = 1'b0;
    lat = 0; nld = 0; nrd = 0; rdat = '0;
    for (int n = 1; n <= 20; n++) begin
      if (bif2.load) nld++;
      if (bif2.rd) nrd++;
      if (bif2.done) begin
        lat = n; rdat = bif2.rdata; break;
      end
      @(negedge clk);
    end
    chk("rw2_lat",   32'(lat), 32'd5);
    chk("rw2_rd",    32'(nrd), 32'd3);
    chk("rw2_load",  32'(nld), 32'd1);
    chk("rw2_rdata", rdat, 32'hDEADBEEF);

    // second req pulsed during READ is dropped, not queued
    @(negedge clk);
    bif0.req = 1'b1; bif0.we = 1'b0; bif0.addr = 32'h40;
    @(negedge clk);
    bif0.req = 1'b0;
    nld = 0; ndone = 0; rdat = '0;
    for (int n = 1; n <= 8; n++) begin
      if (n == 2) begin
        bif0.req = 1'b1; bif0.addr = 32'h44;
      end
      if (n == 3) bif0.req = 1'b0;
      if (bif0.load) nld++;
      if (bif0.done) begin
        ndone++; rdat = bif0.rdata;
      end
      if (n < 8) @(negedge clk);
    end
    chk("busy_load",  32'(nld), 32'd1);
    chk("busy_done",  32'(ndone), 32'd1);
    chk("busy_rdata", rdat, 32'hDEADBEEF);
    chk("busy_ready", 32'(bif0.ready), 32'd1);

    // reset lands on the WRITE cycle: no commit
    @(negedge clk);
    bif0.req = 1'b1; bif0.we = 1'b1;
    bif0.addr = 32'h48; bif0.wdata = 32'h12345678;
    @(negedge clk);
    bif0.req = 1'b0;
    chk("rw_load", 32'(bif0.load), 32'd1);
    @(negedge clk);
    chk("rw_wr_pre", 32'(bif0.wr), 32'd1);
    rst = 1'b1;
    #1;
    chk("rw_wr_rst", 32'(bif0.wr), 32'd0);
    chk("rw_oe_rst", 32'(bif0.m_oe), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    chk("rw_ready", 32'(bif0.ready), 32'd1);
    chk("rw_done",  32'(bif0.done), 32'd0);
    chk("rw_rdata", bif0.rdata, 32'h0);
    xact(1'b0, 32'h48, 32'h0,
         lat, nld, nrd, nwr, rdat, rdy_d, rdy_a);
    chk("rw_rb_lat",  32'(lat), 32'd3);
    chk("rw_rb_data", rdat, 32'h11111111);

    chk("protocol", 32'(viol), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end
endmodule
